// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program counter and next-PC selection for the single-cycle MIPS
//            core. Drives the instruction memory word address, tracks the
//            RUN/HALT/FAULT state and counts retired instructions.
// Ports    : clk, resetpc (async, active high)
//            stall, halt_req, branch_taken/branch_offset, jump/jump_target,
//            jr/jr_addr                      -- next-PC controls
//            pc, pc_plus4, addr              -- current PC, link value, word index
//            halted, fault, retired          -- status and retired count
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ADDR_W       = 8,
  // Reset value of the retired counter; 0 in normal use.
  parameter logic [15:0] RETIRED_INIT = 16'h0000
) (
  input  logic              clk,
  input  logic              resetpc,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jr,
  input  logic [31:0]       jr_addr,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [ADDR_W-1:0] addr,
  output logic              halted,
  output logic              fault,
  output logic [15:0]       retired
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_HALT  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [31:0] r_pc;
  logic [1:0]  r_state;
  logic [15:0] r_retired;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_pc_next;
  logic [1:0]  w_state_next;
  logic        w_retire;

  assign w_pc_plus4 = r_pc + 32'd4;
  // Branch immediate is a signed word offset: sign-extend, then scale by 4.
  assign w_br_off   = {{14{branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    w_pc_next    = r_pc;
    w_state_next = r_state;
    w_retire     = 1'b0;
    if (r_state == S_RUN) begin
      if (halt_req) begin
        // The halting instruction itself retires; PC stays put.
        w_state_next = S_HALT;
        w_retire     = 1'b1;
      end else if (stall) begin
        // Hold PC; any redirect this cycle is dropped and re-presented.
        w_pc_next = r_pc;
      end else if (jr && (jr_addr[1:0] != 2'b00)) begin
        w_state_next = S_FAULT;
      end else begin
        w_retire = 1'b1;
        if (jr) begin
          w_pc_next = jr_addr;
        end else if (jump) begin
          w_pc_next = {w_pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
          w_pc_next = w_pc_plus4 + w_br_off;
        end else begin
          w_pc_next = w_pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge resetpc) begin
    if (resetpc) begin
      r_pc      <= RESET_PC;
      r_state   <= S_RUN;
      r_retired <= RETIRED_INIT;
    end else begin
      r_pc    <= w_pc_next;
      r_state <= w_state_next;
      // Saturating count: sticks at all-ones rather than wrapping.
      if (w_retire && (r_retired != 16'hFFFF)) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  // Plain slice: PCs beyond the memory window wrap the word index.
  assign addr     = r_pc[ADDR_W+1:2];
  assign halted   = (r_state == S_HALT);
  assign fault    = (r_state == S_FAULT);
  assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit. A reference model of the
//            next-PC rules pushes expected state into a queue after each edge;
//            the DUT outputs are popped and compared shortly after.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

  localparam logic [1:0] M_RUN   = 2'd0;
  localparam logic [1:0] M_HALT  = 2'd1;
  localparam logic [1:0] M_FAULT = 2'd2;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] ret;
    logic        h;
    logic        f;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetpc, stall, halt_req, branch_taken, jump, jr;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] jr_addr;
  logic [31:0] pc, pc_plus4;
  logic [7:0]  addr;
  logic        halted, fault;
  logic [15:0] retired;

  // Second instance: wrap past 1 KiB and retired saturation.
  logic        rb;
  logic [31:0] pc_b, pc_plus4_b;
  logic [7:0]  addr_b;
  logic        halted_b, fault_b;
  logic [15:0] retired_b;

  int total = 0;
  int bad   = 0;

  exp_t q[$];
  exp_t qb[$];

  logic [31:0] m_pc;
  logic [15:0] m_ret;
  logic [1:0]  m_st;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0), .ADDR_W(8)) dut (
    .clk(clk), .resetpc(resetpc), .stall(stall), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
    .pc(pc), .pc_plus4(pc_plus4), .addr(addr), .halted(halted),
    .fault(fault), .retired(retired)
  );

  pc_fetch_unit #(.RESET_PC(32'h0000_03FC), .ADDR_W(8), .RETIRED_INIT(16'hFFFC)) dut_b (
    .clk(clk), .resetpc(rb), .stall(1'b0), .halt_req(1'b0),
    .branch_taken(1'b0), .branch_offset(16'h0),
    .jump(1'b0), .jump_target(26'h0), .jr(1'b0), .jr_addr(32'h0),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .addr(addr_b), .halted(halted_b),
    .fault(fault_b), .retired(retired_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.pc = m_pc; e.ret = m_ret;
    e.h = (m_st == M_HALT); e.f = (m_st == M_FAULT);
    q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    logic [31:0] p4;
    e  = q.pop_front();
    p4 = e.pc + 32'd4;
    chk({tag, ".pc"},      pc,                e.pc);
    chk({tag, ".pc_plus4"}, pc_plus4,         p4);
    chk({tag, ".addr"},    {24'h0, addr},     {24'h0, e.pc[9:2]});
    chk({tag, ".halted"},  {31'h0, halted},   {31'h0, e.h});
    chk({tag, ".fault"},   {31'h0, fault},    {31'h0, e.f});
    chk({tag, ".retired"}, {16'h0, retired},  {16'h0, e.ret});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ret = 16'h0; m_st = M_RUN;
  endtask

  // Reference model of one rising edge, using the inputs as currently driven.
  task automatic model_edge();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    if (m_st == M_RUN) begin
      if (halt_req) begin
        m_st = M_HALT;
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (jr && jr_addr[1:0] != 2'b00) begin
        m_st = M_FAULT;
      end else begin
        if (jr)                m_pc = jr_addr;
        else if (jump)         m_pc = {p4[31:28], jump_target, 2'b00};
        else if (branch_taken) m_pc = p4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        else                   m_pc = p4;
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
      end
    end
  endtask

  task automatic idle();
    stall = 0; halt_req = 0; branch_taken = 0; branch_offset = 16'h0;
    jump = 0; jump_target = 26'h0; jr = 0; jr_addr = 32'h0;
  endtask

  // One clock: model the edge, push expectation, then compare 1 time unit later.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    push_model();
    #1;
    pop_check(tag);
  endtask

  initial begin
    idle();
    rb = 1'b1;
    resetpc = 1'b1;
    model_reset();
    #2;
    push_model(); pop_check("reset");
    @(negedge clk); resetpc = 1'b0;

    // Free run: 4,8,12,16,20
    for (int i = 0; i < 5; i++) cyc("seq");
    chk("seq.pc20", pc, 32'd20);
    chk("seq.ret5", {16'h0, retired}, 32'd5);

    // Reach 0x20, then backward branch to 0x0C
    for (int i = 0; i < 3; i++) cyc("seq2");
    branch_taken = 1; branch_offset = 16'hFFFA;
    cyc("br_back");
    chk("br_back.pc", pc, 32'h0C);
    chk("br_back.addr", {24'h0, addr}, 32'd3);
    idle(); jr = 1; jr_addr = 32'h20;
    cyc("jr20");
    idle(); branch_taken = 1; branch_offset = 16'h0003;
    cyc("br_fwd");
    chk("br_fwd.pc", pc, 32'h30);

    // Jump within the same 256 MiB region, then jr beats jump
    idle(); jr = 1; jr_addr = 32'h1000_0040;
    cyc("jr_far");
    idle(); jump = 1; jump_target = 26'h10;
    cyc("jump");
    chk("jump.pc", pc, 32'h1000_0040);
    jr = 1; jr_addr = 32'h88; branch_taken = 1; branch_offset = 16'h7;
    cyc("prio");
    chk("prio.pc", pc, 32'h88);
    idle(); jump = 1; jump_target = 26'h3; branch_taken = 1; branch_offset = 16'h40;
    cyc("prio_jb");

    // Stall 3 cycles with redirects presented: all discarded
    idle(); stall = 1; jump = 1; jump_target = 26'h55;
    for (int i = 0; i < 3; i++) cyc("stall");
    chk("stall.pc", pc, 32'h0C);
    idle(); cyc("post_stall");

    // Halt with stall: halts and retires once, then frozen
    stall = 1; halt_req = 1;
    cyc("halt");
    chk("halt.flag", {31'h0, halted}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(); jr = 1; jr_addr = 32'h200; branch_taken = $urandom_range(0, 1);
      cyc("halt_frozen");
    end

    // Asynchronous reset while halted, checked before the next edge
    idle();
    @(negedge clk);
    resetpc = 1'b1;
    #1;
    model_reset();
    push_model(); pop_check("rst_halt");
    @(negedge clk); resetpc = 1'b0;
    cyc("after_rst");

    // Misaligned JR faults; state frozen for 10 cycles
    jr = 1; jr_addr = 32'h86;
    cyc("jr_mis");
    chk("jr_mis.fault", {31'h0, fault}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      idle(); jump = 1; jump_target = 26'($urandom);
      cyc("fault_frozen");
    end
    idle();

    // Instance B: wrap from 0x3FC and saturate retired
    @(negedge clk);
    chk("b.rst_pc", pc_b, 32'h3FC);
    chk("b.rst_addr", {24'h0, addr_b}, 32'hFF);
    rb = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      exp_t e;
      e.pc  = 32'h3FC + 32'(4 * i);
      e.ret = (i >= 3) ? 16'hFFFF : 16'(16'hFFFC + i);
      e.h = 1'b0; e.f = 1'b0;
      @(posedge clk);
      qb.push_back(e);
      #1;
      e = qb.pop_front();
      chk("b.pc", pc_b, e.pc);
      chk("b.pc_plus4", pc_plus4_b, e.pc + 32'd4);
      chk("b.addr", {24'h0, addr_b}, {24'h0, e.pc[9:2]});
      chk("b.retired", {16'h0, retired_b}, {16'h0, e.ret});
      chk("b.flags", {30'h0, halted_b, fault_b}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
